// File: rtl/irq_ctrl_if.sv
// Bridge register port plus CPU interrupt handshake for irq_ctrl.
// Slave is the controller; master is the bridge/CPU side.
interface irq_ctrl_if #(parameter int N = 6);
  logic [31:0]  Addr;
  logic         WE;
  logic [31:0]  Din;
  logic [31:0]  Dout;
  logic         irq_req;
  logic         irq_ack;
  logic [2:0]   vector;
  logic [N-1:0] HWInt;

  modport slave  (input  Addr, WE, Din, irq_ack,
                  output Dout, irq_req, vector, HWInt);
  modport master (output Addr, WE, Din, irq_ack,
                  input  Dout, irq_req, vector, HWInt);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises N sources, latches pending bits (edge or level),
// masks and resolves fixed priority, and runs a req/ack/EOI handshake with the CPU.
module irq_ctrl #(
   parameter int             N        = 6,
   parameter logic [N-1:0]   MODE_RST = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] irq_src,
   irq_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

   state_t       state, state_next;
   logic [N-1:0] s1, s2, s3;
   logic [N-1:0] pend, pend_next, mask, mode, hwint;
   logic [N-1:0] eff, rise, clr;
   logic [2:0]   vector, vector_next, vector_d;
   logic [1:0]   sel;
   logic         wr_pend, wr_mask, wr_mode, eoi, ack_take;
   logic         unused_bits;

   assign sel     = bus.Addr[3:2];
   assign wr_pend = bus.WE && (sel == 2'd0);
   assign wr_mask = bus.WE && (sel == 2'd1);
   assign wr_mode = bus.WE && (sel == 2'd2);
   assign eoi     = bus.WE && (sel == 2'd3);
   assign unused_bits = ^{bus.Addr[31:4], bus.Addr[1:0], bus.Din};

   assign eff  = pend & mask;
   assign rise = s2 & ~s3;

   always_comb begin
      vector_next = '0;
      for (int i = N - 1; i >= 0; i--)
         if (eff[i]) vector_next = 3'(i);
   end

   // An ack with nothing eligible (eff==0) must not clear anything.
   assign ack_take = bus.irq_ack && (state == REQ) && (|eff);

   always_comb begin
      clr       = '0;
      pend_next = '0;
      for (int i = 0; i < N; i++) begin
         clr[i]       = (wr_pend && bus.Din[i]) || (ack_take && (vector_next == 3'(i)));
         pend_next[i] = mode[i] ? (rise[i] | (pend[i] & ~clr[i])) : s2[i];
      end
   end

   always_comb begin
      state_next = state;
      vector_d   = vector;
      case (state)
         IDLE: if (|eff) state_next = REQ;
         REQ: begin
            if (ack_take) begin
               state_next = SERV;
               vector_d   = vector_next;
            end else if (!(|eff)) begin
               state_next = IDLE;
            end
         end
         SERV: if (eoi) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1     <= '0;
         s2     <= '0;
         s3     <= '0;
         pend   <= '0;
         mask   <= '0;
         mode   <= MODE_RST;
         hwint  <= '0;
         vector <= '0;
         state  <= IDLE;
      end else begin
         s1     <= irq_src;
         s2     <= s1;
         s3     <= s2;
         pend   <= pend_next;
         hwint  <= eff;
         vector <= vector_d;
         state  <= state_next;
         if (wr_mask) mask <= bus.Din[N-1:0];
         if (wr_mode) mode <= bus.Din[N-1:0];
      end
   end

   always_comb begin
      bus.Dout = '0;
      case (sel)
         2'd0: bus.Dout = {{(32-N){1'b0}}, pend};
         2'd1: bus.Dout = {{(32-N){1'b0}}, mask};
         2'd2: bus.Dout = {{(32-N){1'b0}}, mode};
         default: bus.Dout = {state == SERV, state == REQ, 27'b0, vector};
      endcase
   end

   assign bus.irq_req = (state == REQ);
   assign bus.vector  = vector;
   assign bus.HWInt   = hwint;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed handshake scenarios then random traffic, each cycle
// compared against a behavioural model of the controller's rules.
module tb_irq_ctrl;
   localparam int N = 6;
   localparam logic [31:0] A_PEND = 32'h0, A_MASK = 32'h4, A_MODE = 32'h8, A_STAT = 32'hC;
   localparam int M_IDLE = 0, M_REQ = 1, M_SERV = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] irq_src;
   irq_ctrl_if #(.N(N)) bus();

   irq_ctrl #(.N(N), .MODE_RST(6'b000000)) dut (
      .clk(clk), .reset(reset), .irq_src(irq_src), .bus(bus));

   always #5 clk = ~clk;

   int ntests = 0, nerr = 0;

   // model state
   bit [N-1:0] m_pend, m_mask, m_mode, m_hw;
   bit [N-1:0] smp [3];   // smp[d]: irq_src sampled d+1 edges ago
   int         m_st, m_vec;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int lowest(input bit [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [31:0] model_read(input bit [1:0] a);
      case (a)
         2'd0: return 32'(m_pend);
         2'd1: return 32'(m_mask);
         2'd2: return 32'(m_mode);
         default: return {m_st == M_SERV, m_st == M_REQ, 27'b0, 3'(m_vec)};
      endcase
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '0; m_mode = '0; m_hw = '0;
      m_st = M_IDLE; m_vec = 0;
      for (int d = 0; d < 3; d++) smp[d] = '0;
   endtask

   // one clock edge of the controller's rules, from pre-edge state and inputs
   task automatic model_step(input bit [1:0] a, input bit we, input bit [31:0] din,
                             input bit ack, input bit [N-1:0] src);
      bit [N-1:0] eff, lvl, edg, clr, np;
      bit took;
      eff  = m_pend & m_mask;
      lvl  = smp[1];                 // synchroniser output seen by PEND logic
      edg  = smp[1] & ~smp[2];
      took = ack && m_st == M_REQ && eff != 0;
      clr  = (we && a == 2'd0) ? din[N-1:0] : '0;
      if (took) clr[lowest(eff)] = 1'b1;
      np   = (m_mode & (edg | (m_pend & ~clr))) | (~m_mode & lvl);
      if (m_st == M_IDLE) begin
         if (eff != 0) m_st = M_REQ;
      end else if (m_st == M_REQ) begin
         if (took) begin m_st = M_SERV; m_vec = lowest(eff); end
         else if (eff == 0) m_st = M_IDLE;
      end else if (we && a == 2'd3) m_st = M_IDLE;
      m_hw = eff;
      if (we && a == 2'd1) m_mask = din[N-1:0];
      if (we && a == 2'd2) m_mode = din[N-1:0];
      m_pend = np;
      smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = src;
   endtask

   task automatic cyc(input logic [31:0] addr, input bit we, input bit [31:0] din,
                      input bit ack, input bit [N-1:0] src);
      bus.Addr = addr; bus.WE = we; bus.Din = din; bus.irq_ack = ack; irq_src = src;
      @(posedge clk);
      model_step(addr[3:2], we, din, ack, src);
      #1;
      chk("irq_req", 32'(bus.irq_req), 32'(m_st == M_REQ));
      chk("vector",  32'(bus.vector),  32'(m_vec));
      chk("hwint",   32'(bus.HWInt),   32'(m_hw));
      chk("dout",    bus.Dout,         model_read(addr[3:2]));
      @(negedge clk);
   endtask

   task automatic idle(input logic [31:0] addr, input int n);
      for (int i = 0; i < n; i++) cyc(addr, 0, 0, 0, '0);
   endtask

   initial begin
      bit [N-1:0]  rsrc;
      bit [1:0]    ra;
      bit          rwe, rack;
      logic [31:0] raddr;

      reset = 1'b0; irq_src = '0;
      bus.Addr = A_MODE; bus.WE = 0; bus.Din = '0; bus.irq_ack = 0;
      model_reset();
      #12;
      chk("rst_req", 32'(bus.irq_req), 0);
      chk("rst_vec", 32'(bus.vector), 0);
      chk("rst_hw",  32'(bus.HWInt), 0);
      chk("rst_mode", bus.Dout, 0);
      @(negedge clk); reset = 1'b1;

      // 1: single edge source
      cyc(A_MODE, 1, 32'h3F, 0, '0);
      cyc(A_MASK, 1, 32'h01, 0, '0);
      cyc(A_PEND, 0, 0, 0, 6'h01);
      cyc(A_PEND, 0, 0, 0, '0);
      cyc(A_PEND, 0, 0, 0, '0);
      chk("t1_pend", bus.Dout, 32'h1);
      chk("t1_req_early", 32'(bus.irq_req), 0);
      cyc(A_PEND, 0, 0, 0, '0);
      chk("t1_req", 32'(bus.irq_req), 1);
      cyc(A_STAT, 0, 0, 1, '0);
      chk("t1_status", bus.Dout, 32'h8000_0000);
      chk("t1_vec", 32'(bus.vector), 0);
      cyc(A_PEND, 0, 0, 0, '0);
      chk("t1_pend_clr", bus.Dout, 0);
      cyc(A_STAT, 1, 0, 0, '0);
      chk("t1_eoi", bus.Dout, 0);
      cyc(A_STAT, 0, 0, 0, '0);
      chk("t1_noreq", 32'(bus.irq_req), 0);

      // 2: priority
      cyc(A_MASK, 1, 32'h07, 0, '0);
      cyc(A_PEND, 0, 0, 0, 6'h06);
      idle(A_PEND, 3);
      cyc(A_PEND, 0, 0, 1, '0);
      chk("t2_vec", 32'(bus.vector), 1);
      chk("t2_pend", bus.Dout, 32'h4);
      cyc(A_STAT, 1, 0, 0, '0);
      chk("t2_eoi_idle", 32'(bus.irq_req), 0);
      cyc(A_STAT, 0, 0, 0, '0);
      chk("t2_rereq", 32'(bus.irq_req), 1);
      cyc(A_STAT, 0, 0, 1, '0);
      chk("t2_vec2", 32'(bus.vector), 2);
      cyc(A_STAT, 1, 0, 0, '0);

      // 3: level mode
      cyc(A_MODE, 1, 0, 0, '0);
      cyc(A_MASK, 1, 32'h02, 0, '0);
      for (int i = 0; i < 4; i++) cyc(A_PEND, 0, 0, 0, 6'h02);
      cyc(A_PEND, 0, 0, 1, 6'h02);
      chk("t3_pend_hold", bus.Dout, 32'h2);
      cyc(A_STAT, 1, 0, 0, 6'h02);
      cyc(A_STAT, 0, 0, 0, 6'h02);
      chk("t3_rereq", 32'(bus.irq_req), 1);
      cyc(A_STAT, 0, 0, 1, 6'h02);
      cyc(A_PEND, 0, 0, 0, '0);
      cyc(A_PEND, 0, 0, 0, '0);
      cyc(A_PEND, 0, 0, 0, '0);
      chk("t3_pend_drop", bus.Dout, 0);
      cyc(A_STAT, 1, 0, 0, '0);
      idle(A_STAT, 3);
      chk("t3_noreq", 32'(bus.irq_req), 0);

      // 4: mask withdrawal, ack in the same cycle ignored
      cyc(A_MODE, 1, 32'h3F, 0, '0);
      cyc(A_MASK, 1, 32'h01, 0, '0);
      cyc(A_PEND, 0, 0, 0, 6'h01);
      idle(A_PEND, 3);
      cyc(A_MASK, 1, 0, 0, '0);
      cyc(A_PEND, 0, 0, 1, '0);
      chk("t4_req", 32'(bus.irq_req), 0);
      chk("t4_pend", bus.Dout, 32'h1);
      cyc(A_STAT, 0, 0, 0, '0);
      chk("t4_state", 32'(bus.Dout[31:30]), 0);
      cyc(A_PEND, 1, 32'h1, 0, '0);

      // 5: W1C versus a new edge in the same cycle
      cyc(A_PEND, 0, 0, 0, 6'h01);
      cyc(A_PEND, 0, 0, 0, '0);
      cyc(A_PEND, 1, 32'h1, 0, '0);
      chk("t5_set_wins", bus.Dout, 32'h1);
      cyc(A_PEND, 1, 32'h1, 0, '0);
      chk("t5_w1c", bus.Dout, 0);

      // 6: async reset while in SERV
      cyc(A_MASK, 1, 32'h06, 0, '0);
      cyc(A_PEND, 0, 0, 0, 6'h06);
      idle(A_PEND, 3);
      cyc(A_PEND, 0, 0, 1, '0);
      cyc(A_PEND, 0, 0, 0, 6'h08);
      chk("t6_pre_vec", 32'(bus.vector), 1);
      chk("t6_pre_hw", 32'(bus.HWInt), 32'h4);
      #2 reset = 1'b0;
      #1;
      model_reset();
      chk("t6_req", 32'(bus.irq_req), 0);
      chk("t6_vec", 32'(bus.vector), 0);
      chk("t6_hw", 32'(bus.HWInt), 0);
      chk("t6_pend", bus.Dout, 0);
      @(negedge clk); reset = 1'b1;
      idle(A_PEND, 4);
      chk("t6_pend_after", bus.Dout, 0);
      cyc(A_STAT, 0, 0, 0, '0);
      chk("t6_status", bus.Dout, 0);

      // random traffic
      rsrc = '0;
      for (int n = 0; n < 800; n++) begin
         ra    = 2'($urandom_range(3));
         rwe   = ($urandom_range(3) == 0);
         rack  = bus.irq_req ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
         rsrc  = rsrc ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
         raddr = ($urandom & ~32'hC) | {28'h0, ra, 2'b00};
         cyc(raddr, rwe, $urandom, rack, rsrc);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nerr);
      $finish;
   end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Memory-mapped interrupt controller between the device IRQ lines (Timer0, Timer1, external interrupt) and the CPU.
- Synchronizes the sources and detects edges or levels per source.
- Latches pending bits, applies a mask and resolves a fixed priority.
- Presents one request to the CPU with a req/ack/EOI handshake.
- Sits behind the Bridge as a device, with its register window decoded by the Bridge, and drives the CPU's HWInt mirror.

Parameters:
- N, 6, number of interrupt sources (1..8); bit 0 has the highest priority.
- MODE_RST, 6'b000000, reset value of the MODE register (0 = level, 1 = edge).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; all state clears while low.
- Addr  in  32  device address from the Bridge; only Addr[3:2] is decoded.
- WE  in  1  register write enable from the Bridge.
- Din  in  32  write data.
- Dout  out  32  read data, combinational on Addr[3:2].
- irq_src  in  N  raw interrupt sources; may be asynchronous.
- irq_req  out  1  interrupt request to the CPU.
- irq_ack  in  1  one-cycle CPU acknowledge pulse.
- vector  out  3  index of the source being serviced.
- HWInt  out  N  registered copy of PEND & MASK, for Cause.IP.

Behaviour:
- Reset (reset low, async):
  - sync flops, PEND, MASK, vector, HWInt and irq_req are 0; MODE = MODE_RST; state = IDLE.
  - Reset mid-handshake abandons it; there is no recovery of in-service state.
- Synchronizer:
  - irq_src -> s1 -> s2 (two flops), plus s3 = s2 delayed one cycle for edge detection.
- Pending update, per bit i, every cycle:
  - Level mode (MODE[i]=0): PEND[i] <= s2[i]. W1C and ack have no effect.
  - Edge mode (MODE[i]=1): PEND[i] <= (s2[i] & ~s3[i]) | (PEND[i] & ~clr[i]).
  - clr[i] = (WE && Addr[3:2]==0 && Din[i]) | (ack_take && vector_next==i).
  - When a set and a clear hit the same cycle, the set wins.
- Latency: a source high at sampling edge k gives s2 at k+1, PEND at k+2, and HWInt plus the IDLE->REQ transition at k+3.
- Register map (Addr[3:2]):
  - 0 PEND: read-only, write-1-to-clear for edge bits.
  - 1 MASK: read/write, reset 0.
  - 2 MODE: read/write.
  - 3 STATUS: read {state==SERV at bit31, state==REQ at bit30, 27'b0, vector[2:0]}.
  - Any write to STATUS is EOI.
  - Bits [31:N] read as 0; writes to them are ignored.
- Priority: eff = PEND & MASK; vector_next = lowest set index of eff.
- FSM, three states; irq_req = (state==REQ), registered:
  - IDLE: eff != 0 -> REQ.
  - REQ:
    - irq_ack (ack_take) -> SERV; vector <= vector_next; the acked edge-mode bit is cleared.
    - eff == 0 with no ack (source masked or W1C'd) -> IDLE, irq_req drops.
    - ack and eff==0 in the same cycle -> IDLE, vector unchanged.
  - SERV:
    - irq_req = 0; new pending bits still latch.
    - EOI write -> IDLE; REQ can reassert on the following cycle if eff != 0.
- irq_ack in IDLE or SERV is ignored.
- EOI in IDLE or REQ is ignored (no state change).
- A MASK write takes effect on eff the next cycle.
- Nesting is not supported: one in-service source at a time.

Test Plan:
1. Reset then single edge source:
   - Stimulus: MODE=6'h3F, MASK=6'h01, pulse irq_src[0] for 1 cycle.
   - Required: PEND=1 and irq_req=1 three cycles after sampling.
   - Then ack -> vector=0, PEND=0, STATUS=0x80000000; EOI -> STATUS=0, irq_req stays 0.
2. Priority:
   - Stimulus: MASK=6'h07, edges on bits 2 and 1 in the same cycle, then ack.
   - Required: vector=1, PEND=0x4 remaining.
   - Then EOI -> irq_req reasserts the next cycle; ack -> vector=2.
3. Level mode:
   - Stimulus: MODE=0, MASK=6'h02, hold irq_src[1] high, then ack and EOI.
   - Required: PEND[1] stays 1 and REQ reasserts after EOI.
   - Then drop the source -> PEND=0 two cycles later and no further request.
4. Mask withdrawal:
   - Stimulus: in REQ with eff=0x01, write MASK=0.
   - Required: next cycle state=IDLE, irq_req=0, PEND still 0x01; an ack that cycle is ignored.
5. W1C versus a new edge in the same cycle on bit 0:
   - Required: PEND[0] remains 1.
   - W1C alone -> PEND[0]=0.
6. Asynchronous reset asserted while in SERV:
   - Required: state=IDLE, all outputs 0 with no clock edge.
   - After reset is released, pending edges from before the reset are not retained.
